// File: rtl/borrow_skip_sub_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bss_pkg
//  Purpose  : Shared types and default sizes for the borrow-skip subtractor
//  Revision : 1.0 - initial release
// ============================================================================
package bss_pkg;

  localparam int BSS_WIDTH = 16;
  localparam int BSS_GROUP = 4;
  localparam int BSS_NG    = BSS_WIDTH / BSS_GROUP;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bss_state_t;

  // Number of groups for a given operand/group width pair
  function automatic int bss_ng(input int width, input int group);
    return width / group;
  endfunction

endpackage
`default_nettype wire

// File: rtl/borrow_skip_sub_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : borrow_skip_sub_seq_if
//  Purpose  : Operand/result handshake bundle for borrow_skip_sub_seq.
//             The ovf signal exists only when BSS_OVF_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface borrow_skip_sub_seq_if #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
);
  localparam int NG = WIDTH / GROUP;
  localparam int SW = $clog2(NG + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic [SW-1:0]    skip_cnt;
`ifdef BSS_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, skip_cnt
`ifdef BSS_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, skip_cnt
`ifdef BSS_OVF_EN
    , output ovf
`endif
  );

endinterface
`default_nettype wire

// File: rtl/borrow_skip_sub_seq_group.sv
`default_nettype none
// ============================================================================
//  Module   : borrow_skip_group
//  Purpose  : Combinational GROUP-bit borrow-ripple slice with a skip bypass:
//             when the two operand groups are equal the borrow-in passes
//             straight through to the borrow-out.
//  Revision : 1.0 - initial release
// ============================================================================
module borrow_skip_group #(
  parameter int GROUP = 4
) (
  input  wire logic [GROUP-1:0] a,
  input  wire logic [GROUP-1:0] b,
  input  wire logic             bin,
  output logic      [GROUP-1:0] d,
  output logic                  bout,
  output logic                  eq
);

  logic [GROUP:0] ripple_br;

  // Bitwise ripple borrow chain, with equal groups bypassing the chain
  always_comb begin
    ripple_br    = '0;
    d            = '0;
    ripple_br[0] = bin;
    for (int i = 0; i < GROUP; i++) begin
      d[i]           = a[i] ^ b[i] ^ ripple_br[i];
      ripple_br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & ripple_br[i]);
    end
    eq   = (a == b);
    bout = eq ? bin : ripple_br[GROUP];
  end

endmodule
`default_nettype wire

// File: rtl/borrow_skip_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : borrow_skip_sub_seq
//  Purpose  : Sequential a - b - bin subtractor, one GROUP-bit slice per clock,
//             behind valid/ready handshakes. Define BSS_OVF_EN to add the
//             signed-overflow output ovf.
//  Revision : 1.0 - initial release
// ============================================================================
module borrow_skip_sub_seq
  import bss_pkg::*;
#(
  parameter int WIDTH = BSS_WIDTH,
  parameter int GROUP = BSS_GROUP
) (
  input wire logic            clk,
  input wire logic            rst_n,
  borrow_skip_sub_seq_if.slave bus
);

  localparam int NG = bss_ng(WIDTH, GROUP);
  localparam int KW = (NG > 1) ? $clog2(NG) : 1;
  localparam int SW = $clog2(NG + 1);
  localparam logic [KW-1:0] LAST_K = KW'(NG - 1);

  bss_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic [SW-1:0]    skip_cnt_q, skip_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;

  logic [GROUP-1:0] grp_a, grp_b, grp_d;
  logic             grp_bout, grp_eq;

  assign grp_a = a_q[int'(k_q)*GROUP +: GROUP];
  assign grp_b = b_q[int'(k_q)*GROUP +: GROUP];

  borrow_skip_group #(.GROUP(GROUP)) u_group (
    .a    (grp_a),
    .b    (grp_b),
    .bin  (br_q),
    .d    (grp_d),
    .bout (grp_bout),
    .eq   (grp_eq)
  );

  // Next-state logic: accept operands, step one group per cycle, hold result
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    br_d        = br_q;
    k_d         = k_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
    skip_cnt_d  = skip_cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          br_d       = bus.bin;
          k_d        = '0;
          skip_cnt_d = '0;
          diff_d     = '0;
          bout_d     = 1'b0;
          ovf_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        diff_d[int'(k_q)*GROUP +: GROUP] = grp_d;
        br_d = grp_bout;
        k_d  = k_q + KW'(1);
        if (grp_eq) begin
          skip_cnt_d = skip_cnt_q + SW'(1);
        end
        if (k_q == LAST_K) begin
          bout_d      = grp_bout;
          // The top group's MSB is the result sign bit
          ovf_d       = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                        (grp_d[GROUP-1] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      br_q        <= 1'b0;
      k_q         <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      skip_cnt_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      br_q        <= br_d;
      k_q         <= k_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      skip_cnt_q  <= skip_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.skip_cnt  = skip_cnt_q;
`ifdef BSS_OVF_EN
  assign bus.ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_borrow_skip_sub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_borrow_skip_sub_seq
//  Purpose  : Self-checking bench for borrow_skip_sub_seq (directed cases plus
//             random operands against an arithmetic reference model)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_borrow_skip_sub_seq;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  borrow_skip_sub_seq_if #(.WIDTH(16), .GROUP(4)) bus ();

  borrow_skip_sub_seq #(.WIDTH(16), .GROUP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full transaction; result held under back-pressure for 'hold' cycles
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv,
                       input logic tbin, input int hold);
    logic [16:0] full;
    logic [15:0] exp_diff;
    logic        exp_bout;
    logic        exp_ovf;
    int          exp_skip;
    int          n;
    int          cyc;
    full     = {1'b0, ta} - {1'b0, tbv} - {16'd0, tbin};
    exp_diff = full[15:0];
    exp_bout = full[16];
    exp_skip = 0;
    for (int g = 0; g < 4; g++)
      if (ta[g*4 +: 4] == tbv[g*4 +: 4]) exp_skip++;
    exp_ovf = (ta[15] != tbv[15]) && (exp_diff[15] != ta[15]);

    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tbv;
    bus.bin      = tbin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.bin      = 1'($urandom);
    check("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
    cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, 32'd4);
    check("diff", {16'd0, bus.diff}, {16'd0, exp_diff});
    check("bout", {31'd0, bus.bout}, {31'd0, exp_bout});
    check("skip_cnt", {29'd0, bus.skip_cnt}, exp_skip);
`ifdef BSS_OVF_EN
    check("ovf", {31'd0, bus.ovf}, {31'd0, exp_ovf});
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check("hold_diff", {16'd0, bus.diff}, {16'd0, exp_diff});
      check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("release_valid", {31'd0, bus.out_valid}, 32'd0);
    check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    vectors       = 0;
    miscompares   = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_diff", {16'd0, bus.diff}, 32'd0);
    check("rst_bout", {31'd0, bus.bout}, 32'd0);
    check("rst_skip", {29'd0, bus.skip_cnt}, 32'd0);
`ifdef BSS_OVF_EN
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
    rst_n = 1'b1;

    // Directed cases
    do_op(16'h1234, 16'h0234, 1'b0, 0);
    do_op(16'h0000, 16'h0001, 1'b0, 0);
    do_op(16'hABCD, 16'hABCD, 1'b1, 0);
    do_op(16'hABCD, 16'hABCD, 1'b0, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 10);

    // Reset while group 2 is being processed
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 16'h9876;
    bus.b        = 16'h1111;
    bus.bin      = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("midrst_diff", {16'd0, bus.diff}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h0005, 16'h0003, 1'b0, 0);

    // Random operands; some nibbles forced equal to exercise the skip path
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      for (int g = 0; g < 4; g++)
        if ($urandom_range(0, 1) == 1) rb[g*4 +: 4] = ra[g*4 +: 4];
      do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
